instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 69 ++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch with branch redirect and decode handshake
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] inst_o,
  output logic [10:0] opcode_o,
  output logic [63:0] inst_pc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  input  logic        resolve_valid_i,
  input  logic        branch_i,
  input  logic        uncond_branch_i,
  input  logic        zero_i,
  input  logic [63:0] resolve_pc_i,
  input  logic [63:0] imm64_i
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d, drop_addr_q, drop_addr_d, inst_pc_q, inst_pc_d;
  logic [31:0] inst_q, inst_d;
  logic        redirect, accept, capture;
  logic [63:0] target, addr_raw;
  always_comb begin
    redirect    = resolve_valid_i & (uncond_branch_i | (branch_i & zero_i));
    target      = resolve_pc_i + (imm64_i << 2);
    accept      = (state_q == HOLD) & inst_ready_i;
    capture     = (state_q == REQ) & imem_ack_i & ~redirect;
    state_d     = (state_q == IDLE) ? REQ :
                  (state_q == REQ)  ? (imem_ack_i ? (redirect ? REQ : HOLD) : (redirect ? DROP : REQ)) :
                  (state_q == DROP) ? (imem_ack_i ? REQ : DROP) :
                  ((redirect | accept) ? REQ : HOLD);
    fetch_pc_d  = redirect ? target : accept ? inst_pc_q + 64'd4 : fetch_pc_q;
    // DROP keeps presenting the abandoned address until memory answers it
    drop_addr_d = ((state_q == REQ) & redirect & ~imem_ack_i) ? fetch_pc_q : drop_addr_q;
    inst_d      = capture ? imem_data_i : inst_q;
    inst_pc_d   = capture ? fetch_pc_q : inst_pc_q;
    addr_raw    = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= 64'h0;
      inst_q      <= 32'h0;
      inst_pc_q   <= 64'h0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
    end
  end
  assign imem_req_o   = (state_q == REQ) | (state_q == DROP);
  assign imem_addr_o  = {addr_raw[63:2], 2'b00};
  assign inst_o       = inst_q;
  assign opcode_o     = inst_q[31:21];
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = state_q == HOLD;
endmodule
